pong_paddle_ai: RTL

- Parametrised hardware paddle controller for the pong core.
- Drives one paddle's up/down inputs from ball and paddle positions, replacing the behavioural tracking loop used in simulation.
- Adds reaction delay, a movement rate limit, a return-to-centre mode and a manual pass-through.
- One instance per paddle; the SIDE parameter selects left or right.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_ai_lfsr.sv | 22 ++
 rtl/pong_paddle_ai.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong paddle controller: coordinate defaults,
// mode and AI state encodings, and the jitter LFSR seed.
package pong_pkg;

  localparam int DEF_COORD_W  = 7;
  localparam int DEF_FIELD_H  = 128;
  localparam int DEF_PADDLE_H = 4;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_TRACK  = 2'b01;
  localparam logic [1:0] MODE_RETURN = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_REACT     = 2'd1,
    ST_MOVE_UP   = 2'd2,
    ST_MOVE_DOWN = 2'd3
  } ai_state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/pong_ai_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to jitter the paddle
// reaction delay; advances on every clock edge.
module pong_ai_lfsr
  import pong_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] out
);

  logic fb;

  assign fb = out[7] ^ out[5] ^ out[4] ^ out[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= SEED;
    else       out <= {out[6:0], fb};
  end

endmodule

// File: rtl/pong_paddle_ai.sv
// Hardware paddle controller: tracks the ball with reaction delay and move
// rate limiting. Define PONG_AI_JITTER_EN to add LFSR jitter to the delay.
//
// state        | meaning
// -------------+------------------------------------------------
// ST_HOLD      | idle, paddle already covers the target
// ST_REACT     | reaction delay counting down before a move
// ST_MOVE_UP   | pulsing up once every MOVE_PERIOD cycles
// ST_MOVE_DOWN | pulsing down once every MOVE_PERIOD cycles
module pong_paddle_ai
  import pong_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int FIELD_H     = DEF_FIELD_H,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int REACT_DELAY = 2,
  parameter int MOVE_PERIOD = 2,
  parameter int SIDE        = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddle_y,
  input  logic               manual_up,
  input  logic               manual_down,
  output logic               up,
  output logic               down,
  output logic [1:0]         ai_state
);

  localparam int RATE_W  = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  // Wide enough for REACT_DELAY plus the largest jitter offset of 3.
  localparam int REACT_W = $clog2(REACT_DELAY + 5);
  localparam int CW1     = COORD_W + 1;

  localparam logic [COORD_W-1:0] CENTRE     = COORD_W'((FIELD_H - PADDLE_H) / 2);
  localparam logic [CW1-1:0]     Y_MAX      = CW1'(FIELD_H - PADDLE_H);
  localparam logic [CW1-1:0]     PAD_SPAN   = CW1'(PADDLE_H - 1);
  localparam logic [RATE_W-1:0]  RATE_LAST  = RATE_W'(MOVE_PERIOD - 1);

  ai_state_t           state, state_nxt;
  logic [REACT_W-1:0]  react_cnt, react_nxt;
  logic [RATE_W-1:0]   rate_cnt, rate_nxt;
  logic                up_nxt, down_nxt;

  logic [COORD_W-1:0]  prev_x;
  logic                approaching;
  logic                toward;
  logic [COORD_W-1:0]  target;
  logic [CW1-1:0]      paddle_bot;
  logic                want_up, want_down, want_any;
  logic                ai_off;
  logic [REACT_W-1:0]  d_eff;

`ifdef PONG_AI_JITTER_EN
  logic [7:0] lfsr_q;

  pong_ai_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr_q)
  );

  assign d_eff = REACT_W'(REACT_DELAY) + REACT_W'(lfsr_q[1:0]);
`else
  assign d_eff = REACT_W'(REACT_DELAY);
`endif

  assign toward = (SIDE == 0) ? (ball_x < prev_x) : (ball_x > prev_x);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_x      <= '0;
      approaching <= 1'b1;
    end else begin
      prev_x <= ball_x;
      if (toward)                 approaching <= 1'b1;
      else if (ball_x != prev_x)  approaching <= 1'b0;
    end
  end

  assign target     = (mode == MODE_RETURN && !approaching) ? CENTRE : ball_y;
  assign paddle_bot = {1'b0, paddle_y} + PAD_SPAN;
  assign want_up    = ({1'b0, target} < {1'b0, paddle_y}) && (paddle_y != '0);
  assign want_down  = ({1'b0, target} > paddle_bot) && ({1'b0, paddle_y} < Y_MAX);
  assign want_any   = want_up || want_down;
  assign ai_off     = !enable || (mode != MODE_TRACK && mode != MODE_RETURN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HOLD;
      react_cnt <= '0;
      rate_cnt  <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
    end else begin
      state     <= state_nxt;
      react_cnt <= react_nxt;
      rate_cnt  <= rate_nxt;
      up        <= up_nxt;
      down      <= down_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    react_nxt = react_cnt;
    rate_nxt  = rate_cnt;
    if (ai_off) begin
      state_nxt = ST_HOLD;
      react_nxt = '0;
      rate_nxt  = '0;
    end else begin
      case (state)
        ST_HOLD: begin
          react_nxt = '0;
          rate_nxt  = '0;
          if (want_any) begin
            if (d_eff == '0) begin
              state_nxt = want_up ? ST_MOVE_UP : ST_MOVE_DOWN;
            end else begin
              state_nxt = ST_REACT;
              react_nxt = d_eff - 1'b1;
            end
          end
        end
        ST_REACT: begin
          rate_nxt = '0;
          if (!want_any) begin
            state_nxt = ST_HOLD;
            react_nxt = '0;
          end else if (react_cnt == '0) begin
            state_nxt = want_up ? ST_MOVE_UP : ST_MOVE_DOWN;
          end else begin
            react_nxt = react_cnt - 1'b1;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (!want_any) begin
            state_nxt = ST_HOLD;
            rate_nxt  = '0;
          end else if ((state == ST_MOVE_UP && want_down) ||
                       (state == ST_MOVE_DOWN && want_up)) begin
            // Reversal always re-arms the reaction delay.
            rate_nxt = '0;
            if (d_eff == '0) begin
              state_nxt = want_up ? ST_MOVE_UP : ST_MOVE_DOWN;
            end else begin
              state_nxt = ST_REACT;
              react_nxt = d_eff - 1'b1;
            end
          end else begin
            rate_nxt = (rate_cnt == RATE_LAST) ? '0 : rate_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_HOLD;
          react_nxt = '0;
          rate_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    up_nxt   = 1'b0;
    down_nxt = 1'b0;
    if (ai_off) begin
      up_nxt   = enable && manual_up && !manual_down;
      down_nxt = enable && manual_down && !manual_up;
    end else begin
      up_nxt   = (state_nxt == ST_MOVE_UP)   && (rate_nxt == '0);
      down_nxt = (state_nxt == ST_MOVE_DOWN) && (rate_nxt == '0);
    end
  end

  assign ai_state = state;

endmodule
